// File: rtl/ddr3_wb_arbiter.sv
// rtl/ddr3_wb_arbiter.sv - two-master round-robin arbiter for the DDR3 pipelined Wishbone port
// Optional ARB_BURST_LIMIT_EN: preempt the owner after MAX_BURST accepted strobes while the other master waits.
module ddr3_wb_arbiter #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 512,
  parameter int SEL_BITS  = DATA_BITS / 8,
  parameter int AUX_WIDTH = 15,
  parameter int MAX_BURST = 16
) (
  input  logic                 i_controller_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wb0_cyc,
  input  logic                 i_wb0_stb,
  input  logic                 i_wb0_we,
  input  logic [ADDR_BITS-1:0] i_wb0_addr,
  input  logic [DATA_BITS-1:0] i_wb0_data,
  input  logic [SEL_BITS-1:0]  i_wb0_sel,
  input  logic [AUX_WIDTH-1:0] i_wb0_aux,
  output logic                 o_wb0_stall,
  output logic                 o_wb0_ack,
  output logic [DATA_BITS-1:0] o_wb0_data,
  output logic [AUX_WIDTH-1:0] o_wb0_aux,
  input  logic                 i_wb1_cyc,
  input  logic                 i_wb1_stb,
  input  logic                 i_wb1_we,
  input  logic [ADDR_BITS-1:0] i_wb1_addr,
  input  logic [DATA_BITS-1:0] i_wb1_data,
  input  logic [SEL_BITS-1:0]  i_wb1_sel,
  input  logic [AUX_WIDTH-1:0] i_wb1_aux,
  output logic                 o_wb1_stall,
  output logic                 o_wb1_ack,
  output logic [DATA_BITS-1:0] o_wb1_data,
  output logic [AUX_WIDTH-1:0] o_wb1_aux,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_BITS-1:0] o_wb_addr,
  output logic [DATA_BITS-1:0] o_wb_data,
  output logic [SEL_BITS-1:0]  o_wb_sel,
  output logic [AUX_WIDTH:0]   o_wb_aux,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic [DATA_BITS-1:0] i_wb_data,
  input  logic [AUX_WIDTH:0]   i_wb_aux,
  output logic [1:0]           o_grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t state, state_next;
  logic   last_served, last_next;
  logic   preempt;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt;

  assign preempt = (burst_cnt == CW'(MAX_BURST)) &&
                   (((state == G0) && i_wb1_cyc) || ((state == G1) && i_wb0_cyc));

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      burst_cnt <= '0;
    else if (state_next != state)
      burst_cnt <= '0;
    else if (o_wb_stb && !i_wb_stall && (burst_cnt != CW'(MAX_BURST)))
      burst_cnt <= burst_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign preempt    = 1'b0;
  assign unused_cfg = ^MAX_BURST;
`endif

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      last_served <= last_next;
    end
  end

  // Leaving a grant always records the departing owner so a later tie favours the other side
  always_comb begin
    state_next = state;
    last_next  = last_served;
    case (state)
      IDLE: begin
        if (i_wb0_cyc && i_wb1_cyc) state_next = last_served ? G0 : G1;
        else if (i_wb0_cyc)         state_next = G0;
        else if (i_wb1_cyc)         state_next = G1;
      end
      G0: begin
        if (!i_wb0_cyc || preempt) begin
          state_next = i_wb1_cyc ? G1 : IDLE;
          last_next  = 1'b0;
        end
      end
      G1: begin
        if (!i_wb1_cyc || preempt) begin
          state_next = i_wb0_cyc ? G0 : IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_wb_cyc    = 1'b0;
    o_wb_stb    = 1'b0;
    o_wb_we     = 1'b0;
    o_wb_addr   = '0;
    o_wb_data   = '0;
    o_wb_sel    = '0;
    o_wb_aux    = '0;
    o_wb0_stall = 1'b1;
    o_wb1_stall = 1'b1;
    case (state)
      G0: begin
        o_wb_cyc    = i_wb0_cyc;
        o_wb_stb    = i_wb0_stb && !preempt;
        o_wb_we     = i_wb0_we;
        o_wb_addr   = i_wb0_addr;
        o_wb_data   = i_wb0_data;
        o_wb_sel    = i_wb0_sel;
        o_wb_aux    = {1'b0, i_wb0_aux};
        o_wb0_stall = i_wb_stall || preempt;
      end
      G1: begin
        o_wb_cyc    = i_wb1_cyc;
        o_wb_stb    = i_wb1_stb && !preempt;
        o_wb_we     = i_wb1_we;
        o_wb_addr   = i_wb1_addr;
        o_wb_data   = i_wb1_data;
        o_wb_sel    = i_wb1_sel;
        o_wb_aux    = {1'b1, i_wb1_aux};
        o_wb1_stall = i_wb_stall || preempt;
      end
      default: ;
    endcase
  end

  // Returns follow the tag, not the grant; an owner that already dropped cyc never sees them
  assign o_wb0_ack  = i_wb_ack && !i_wb_aux[AUX_WIDTH] && i_wb0_cyc;
  assign o_wb1_ack  = i_wb_ack &&  i_wb_aux[AUX_WIDTH] && i_wb1_cyc;
  assign o_wb0_data = i_wb_data;
  assign o_wb1_data = i_wb_data;
  assign o_wb0_aux  = i_wb_aux[AUX_WIDTH-1:0];
  assign o_wb1_aux  = i_wb_aux[AUX_WIDTH-1:0];
  assign o_grant    = {state == G1, state == G0};

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// tb/tb_ddr3_wb_arbiter.sv - randomized scoreboard bench for ddr3_wb_arbiter
module tb_ddr3_wb_arbiter;
  localparam int AB = 8, DB = 32, SB = 4, AW = 4, MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cyc, stb, we;
  logic [AB-1:0] addr [2];
  logic [DB-1:0] wdata [2];
  logic [SB-1:0] sel [2];
  logic [AW-1:0] maux [2];
  logic [1:0] m_stall, m_ack;
  logic [DB-1:0] m_rdata [2];
  logic [AW-1:0] m_raux [2];
  logic s_cyc, s_stb, s_we, s_stall, s_ack;
  logic [AB-1:0] s_addr;
  logic [DB-1:0] s_wdata, s_rdata;
  logic [SB-1:0] s_sel;
  logic [AW:0] s_aux, s_raux;
  logic [1:0] grant;

  ddr3_wb_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .SEL_BITS(SB), .AUX_WIDTH(AW), .MAX_BURST(MB)) dut (
    .i_controller_clk(clk), .i_rst_n(rst_n),
    .i_wb0_cyc(cyc[0]), .i_wb0_stb(stb[0]), .i_wb0_we(we[0]), .i_wb0_addr(addr[0]),
    .i_wb0_data(wdata[0]), .i_wb0_sel(sel[0]), .i_wb0_aux(maux[0]),
    .o_wb0_stall(m_stall[0]), .o_wb0_ack(m_ack[0]), .o_wb0_data(m_rdata[0]), .o_wb0_aux(m_raux[0]),
    .i_wb1_cyc(cyc[1]), .i_wb1_stb(stb[1]), .i_wb1_we(we[1]), .i_wb1_addr(addr[1]),
    .i_wb1_data(wdata[1]), .i_wb1_sel(sel[1]), .i_wb1_aux(maux[1]),
    .o_wb1_stall(m_stall[1]), .o_wb1_ack(m_ack[1]), .o_wb1_data(m_rdata[1]), .o_wb1_aux(m_raux[1]),
    .o_wb_cyc(s_cyc), .o_wb_stb(s_stb), .o_wb_we(s_we), .o_wb_addr(s_addr),
    .o_wb_data(s_wdata), .o_wb_sel(s_sel), .o_wb_aux(s_aux),
    .i_wb_stall(s_stall), .i_wb_ack(s_ack), .i_wb_data(s_rdata), .i_wb_aux(s_raux),
    .o_grant(grant)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [AW-1:0] aux; logic [DB-1:0] data; } exp_t;
  typedef struct { int due; logic [AW:0] aux; logic [DB-1:0] data; } rsp_t;

  exp_t q0[$], q1[$];
  rsp_t sq[$];
  int n_checks = 0, n_fail = 0;
  int g = -1, mcnt = 0, cycle = 0, last_due = 0;
  bit last = 1'b1, mon_en = 1'b0, stop_new = 1'b0, drained = 1'b0;
  int rem [2];
  bit acc [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] rsp(input logic [AB-1:0] a, input logic t, input logic [AW-1:0] x);
    return {8'h5A, a, 7'd0, t, 4'd0, x};
  endfunction

  function automatic int qsize(input int x);
    return (x == 0) ? q0.size() : q1.size();
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en)
      for (int x = 0; x < 2; x++)
        if (m_ack[x]) begin
          if (qsize(x) == 0) check("ack_unexpected", m_ack[x], 1'b0);
          else begin
            if (x == 0) e = q0.pop_front(); else e = q1.pop_front();
            check("rsp_aux", m_raux[x], e.aux);
            check("rsp_data", m_rdata[x], e.data);
          end
        end
  end

  task automatic new_req(input int x);
    addr[x]  = AB'($urandom);
    wdata[x] = DB'($urandom);
    sel[x]   = SB'($urandom);
    maux[x]  = AW'($urandom);
    we[x]    = 1'($urandom_range(0, 1));
  endtask

  // Reference arbiter: grant owner as an integer, round-robin rules applied directly
  task automatic sample_and_model();
    int nxt;
    bit pre, exp_stb;
    logic [1:0] exp_g;
    exp_t e;
    rsp_t r;
    pre = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    if (g >= 0) pre = (mcnt == MB) && cyc[1-g];
`endif
    exp_g = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    check("grant", grant, exp_g);
    for (int x = 0; x < 2; x++)
      check("stall", m_stall[x], (g == x) ? (s_stall | pre) : 1'b1);
    exp_stb = (g >= 0) && stb[g] && !pre;
    check("bus_cyc", s_cyc, (g >= 0) && cyc[g]);
    check("bus_stb", s_stb, exp_stb);
    if (s_stb && !s_stall) begin
      if (g >= 0) begin
        check("bus_tag", s_aux[AW], g == 1);
        check("bus_aux", s_aux[AW-1:0], maux[g]);
        check("bus_addr", s_addr, addr[g]);
        check("bus_wdata", s_wdata, wdata[g]);
        check("bus_sel", s_sel, sel[g]);
        check("bus_we", s_we, we[g]);
      end
      r.due = cycle + 1 + $urandom_range(0, 2);
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.aux = s_aux;
      r.data = rsp(s_addr, s_aux[AW], s_aux[AW-1:0]);
      sq.push_back(r);
    end
    for (int x = 0; x < 2; x++) begin
      acc[x] = stb[x] && cyc[x] && !m_stall[x];
      if (acc[x]) begin
        e.aux = maux[x];
        e.data = rsp(addr[x], 1'(x), maux[x]);
        if (x == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    if (g < 0) nxt = (cyc == 2'b11) ? (last ? 0 : 1) : (cyc[0] ? 0 : (cyc[1] ? 1 : -1));
    else if (!cyc[g] || pre) begin
      nxt = cyc[1-g] ? 1 - g : -1;
      last = (g == 1);
    end else nxt = g;
    if (nxt != g) mcnt = 0;
    else if (exp_stb && !s_stall && mcnt < MB) mcnt++;
    g = nxt;
  endtask

  task automatic drive_slave();
    rsp_t r;
    s_stall = ($urandom_range(0, 3) == 0);
    if (sq.size() > 0 && sq[0].due <= cycle) begin
      r = sq.pop_front();
      s_ack = 1'b1; s_raux = r.aux; s_rdata = r.data;
    end else begin
      s_ack = 1'b0; s_raux = (AW+1)'($urandom); s_rdata = DB'($urandom);
    end
  endtask

  task automatic drive_masters();
    for (int x = 0; x < 2; x++) begin
      if (acc[x]) begin rem[x]--; new_req(x); end
      if (cyc[x]) begin
        if (rem[x] == 0) begin
          stb[x] = 1'b0;
          if (qsize(x) == 0) cyc[x] = 1'b0;
        end else if (!(stb[x] && !acc[x])) stb[x] = ($urandom_range(0, 3) != 0);
      end else if (!stop_new && $urandom_range(0, 3) == 0) begin
        cyc[x] = 1'b1; stb[x] = 1'b1; rem[x] = $urandom_range(1, 6); new_req(x);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    cyc = '0; stb = '0; we = '0;
    for (int x = 0; x < 2; x++) begin
      addr[x] = '0; wdata[x] = '0; sel[x] = '0; maux[x] = '0; rem[x] = 0; acc[x] = 1'b0;
    end
    s_stall = 1'b0; s_ack = 1'b0; s_rdata = '0; s_raux = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant, 2'b00);
    check("reset_stall", m_stall, 2'b11);
    check("reset_cyc", s_cyc, 1'b0);
    check("reset_stb", s_stb, 1'b0);
    check("reset_ack", m_ack, 2'b00);
    next_cycle();
    rst_n = 1'b1;
    for (int x = 0; x < 2; x++) begin
      cyc[x] = 1'b1; stb[x] = 1'b1; rem[x] = $urandom_range(2, 6); new_req(x);
    end
    mon_en = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      if (c == 1500) stop_new = 1'b1;
      @(negedge clk);
      sample_and_model();
      if (stop_new && cyc == 2'b00 && sq.size() == 0) begin drained = 1'b1; break; end
      next_cycle();
      cycle++;
      drive_slave();
      drive_masters();
    end
    check("drain_done", drained, 1'b1);
    check("drain_pending", q0.size() + q1.size(), 0);
    next_cycle();
    mon_en = 1'b0;
    s_stall = 1'b0; s_ack = 1'b0; cyc = '0; stb = '0;

    cyc = 2'b10; stb = 2'b10;
    next_cycle(); @(negedge clk);
    check("m1_only_grant", grant, 2'b10);
    check("m1_only_stb", s_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, 2'b00);
    check("midrst_stb", s_stb, 1'b0);
    check("midrst_cyc", s_cyc, 1'b0);
    check("midrst_stall", m_stall, 2'b11);
    next_cycle();
    rst_n = 1'b1; cyc = 2'b11; stb = 2'b11; new_req(0); new_req(1);
    next_cycle(); @(negedge clk);
    check("tie_after_reset", grant, 2'b01);
    check("tie_tag", s_aux[AW], 1'b0);
    check("tie_addr", s_addr, addr[0]);
    next_cycle();
    cyc = 2'b10; stb = 2'b10;
    @(negedge clk);
    check("switch_gap_cyc", s_cyc, 1'b0);
    next_cycle(); @(negedge clk);
    check("switch_grant", grant, 2'b10);
    check("switch_tag", s_aux[AW], 1'b1);
    check("switch_cyc", s_cyc, 1'b1);
    next_cycle();
    s_ack = 1'b1; s_raux = {1'b0, 4'h5}; s_rdata = 32'h1234;
    @(negedge clk);
    check("stale_ack", m_ack, 2'b00);
    next_cycle();
    s_raux = {1'b1, 4'h3};
    @(negedge clk);
    check("m1_ack", m_ack, 2'b10);
    check("m1_ack_aux", m_raux[1], 4'h3);
    next_cycle();
    cyc = 2'b11; stb = 2'b11; s_raux = {1'b0, 4'h5}; s_rdata = 32'hCAFE;
    @(negedge clk);
    check("m0_ack_by_tag", m_ack, 2'b01);
    check("m0_ack_aux", m_raux[0], 4'h5);
    check("m0_ack_data", m_rdata[0], 32'hCAFE);
    check("m0_waiting_stall", m_stall[0], 1'b1);
    check("grant_held_m1", grant, 2'b10);
    next_cycle();
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
    next_cycle(); @(negedge clk);
    check("both_drop_idle", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
